// File: rtl/stopwatch_ctrl_if.sv
// Button, rollover and count-control signals between the stopwatch front end
// and its surroundings (buttons, digit counter chain).
interface stopwatch_ctrl_if;
   logic btn_start;
   logic btn_clear;
   logic top_tc;
   logic tick;
   logic clr;
   logic running;
   logic overflow;

   modport master (
      output btn_start, btn_clear, top_tc,
      input  tick, clr, running, overflow
   );

   modport slave (
      input  btn_start, btn_clear, top_tc,
      output tick, clr, running, overflow
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: button synchronise/debounce, IDLE/RUN/PAUSE/OVF
// state machine, count-tick prescaler and clear pulse for the digit counters.
module stopwatch_ctrl #(
   parameter int TickDiv       = 1000000,
   parameter int TickWidth     = 20,
   parameter int DebounceCount = 500000,
   parameter int DebounceWidth = 19
) (
   input  logic            clk,
   input  logic            reset,
   stopwatch_ctrl_if.slave sw
);

   localparam logic [TickWidth-1:0]     TickMax = TickWidth'(TickDiv - 1);
   localparam logic [DebounceWidth-1:0] DbMax   = DebounceWidth'(DebounceCount);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_OVF
   } state_t;

   // Index 0 is start/stop, index 1 is clear.
   logic [1:0]               w_raw;
   logic [1:0]               r_sync1;
   logic [1:0]               r_sync2;
   logic [1:0]               r_stable;
   logic [1:0]               r_press;
   logic [DebounceWidth-1:0] r_db_cnt [2];

   logic                     w_start_p;
   logic                     w_clear_p;

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     w_clr_next;
   logic                     r_clr;
   logic [TickWidth-1:0]     r_presc;
   logic                     w_tick;

   assign w_raw     = {sw.btn_clear, sw.btn_start};
   assign w_start_p = r_press[0];
   assign w_clear_p = r_press[1];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_press  <= '0;
         for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_press <= '0;
         for (int b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_stable[b]) begin
               r_db_cnt[b] <= '0;
            end else if (r_db_cnt[b] == DbMax) begin
               // Accept the new level; only a rising stable level is a press.
               r_stable[b] <= r_sync2[b];
               r_db_cnt[b] <= '0;
               r_press[b]  <= r_sync2[b];
            end else begin
               r_db_cnt[b] <= r_db_cnt[b] + DebounceWidth'(1);
            end
         end
      end
   end

   assign w_tick = (r_state == ST_RUN) && (r_presc == TickMax);

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_state_next = r_state;
      w_clr_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_clear_p)      w_clr_next   = 1'b1;
            else if (w_start_p) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            // Full-scale rollover outranks a simultaneous start/stop press.
            if (w_tick && sw.top_tc) w_state_next = ST_OVF;
            else if (w_start_p)      w_state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (w_clear_p) begin
               w_state_next = ST_IDLE;
               w_clr_next   = 1'b1;
            end else if (w_start_p) begin
               w_state_next = ST_RUN;
            end
         end
         ST_OVF: begin
            if (w_clear_p) begin
               w_state_next = ST_IDLE;
               w_clr_next   = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_clr   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_clr   <= w_clr_next;
      end
   end

   // Prescaler only advances in RUN, so PAUSE resumes mid-period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (w_clr_next) begin
         r_presc <= '0;
      end else if (r_state == ST_RUN) begin
         if (r_presc == TickMax) r_presc <= '0;
         else                    r_presc <= r_presc + TickWidth'(1);
      end
   end

   assign sw.tick     = w_tick;
   assign sw.clr      = r_clr;
   assign sw.running  = (r_state == ST_RUN);
   assign sw.overflow = (r_state == ST_OVF);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model predicts every
// cycle's outputs into a queue, and a negedge monitor compares against the DUT.
module tb_stopwatch_ctrl;

   localparam int TD = 4;
   localparam int DC = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   stopwatch_ctrl_if sw_if ();

   stopwatch_ctrl #(
      .TickDiv      (TD),
      .TickWidth    (3),
      .DebounceCount(DC),
      .DebounceWidth(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sw   (sw_if)
   );

   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_OVF} mstate_e;

   typedef struct packed {
      logic tick;
      logic clr;
      logic running;
      logic overflow;
   } outs_t;

   outs_t   exp_q[$];
   int      n_vec  = 0;
   int      n_fail = 0;
   int      n_cyc  = 0;

   // Model: state by name, elapsed RUN cycles, per-button level history.
   mstate_e m_state;
   int      m_run_cycles;
   bit      m_clr;
   bit      m_pipe [2][2];
   bit      m_stable [2];
   int      m_differ [2];
   bit      m_press [2];

   function automatic void model_reset();
      m_state      = M_IDLE;
      m_run_cycles = 0;
      m_clr        = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_pipe[b][0] = 1'b0;
         m_pipe[b][1] = 1'b0;
         m_stable[b]  = 1'b0;
         m_differ[b]  = 0;
         m_press[b]   = 1'b0;
      end
   endfunction

   function automatic bit model_tick();
      return (m_state == M_RUN) && ((m_run_cycles % TD) == TD - 1);
   endfunction

   function automatic void model_step(input bit raw_s, input bit raw_c, input bit tc);
      bit tk;
      bit sp;
      bit cp;
      bit raw [2];
      bit seen;
      tk     = model_tick();
      sp     = m_press[0];
      cp     = m_press[1];
      raw[0] = raw_s;
      raw[1] = raw_c;
      m_clr  = 1'b0;
      case (m_state)
         M_IDLE:  if (cp) m_clr = 1'b1; else if (sp) m_state = M_RUN;
         M_RUN: begin
            m_run_cycles++;
            if (tk && tc)  m_state = M_OVF;
            else if (sp)   m_state = M_PAUSE;
         end
         M_PAUSE: if (cp) begin m_state = M_IDLE; m_clr = 1'b1; end
                  else if (sp) m_state = M_RUN;
         M_OVF:   if (cp) begin m_state = M_IDLE; m_clr = 1'b1; end
      endcase
      if (m_clr) m_run_cycles = 0;
      // A level is accepted after DC+1 consecutive differing samples, two edges late.
      for (int b = 0; b < 2; b++) begin
         seen         = m_pipe[b][1];
         m_pipe[b][1] = m_pipe[b][0];
         m_pipe[b][0] = raw[b];
         m_press[b]   = 1'b0;
         if (seen == m_stable[b]) begin
            m_differ[b] = 0;
         end else if (m_differ[b] == DC) begin
            m_stable[b] = seen;
            m_differ[b] = 0;
            m_press[b]  = seen;
         end else begin
            m_differ[b]++;
         end
      end
   endfunction

   task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got tick/clr/run/ovf=%b, expected %b",
                  name, n_cyc, actual, expected);
      end
   endtask

   // One clock: advance the model over the edge, then drive the next inputs.
   task automatic cycle(input bit s, input bit c, input int tc_pct, input bit rst_val);
      outs_t e;
      @(posedge clk);
      n_cyc++;
      if (!reset) model_reset();
      else        model_step(sw_if.btn_start, sw_if.btn_clear, sw_if.top_tc);
      #1;
      reset           = rst_val;
      sw_if.btn_start = s;
      sw_if.btn_clear = c;
      if (!rst_val) model_reset();
      sw_if.top_tc = model_tick() && ($urandom_range(0, 99) < tc_pct);
      e.tick     = model_tick();
      e.clr      = m_clr;
      e.running  = (m_state == M_RUN);
      e.overflow = (m_state == M_OVF);
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input bit s, input bit c, input int tc_pct);
      for (int i = 0; i < n; i++) cycle(s, c, tc_pct, 1'b1);
   endtask

   always @(negedge clk) begin : monitor
      outs_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs", {sw_if.tick, sw_if.clr, sw_if.running, sw_if.overflow}, e);
      end
   end

   initial begin
      int len;
      bit s;
      bit c;
      reset           = 1'b0;
      sw_if.btn_start = 1'b0;
      sw_if.btn_clear = 1'b0;
      sw_if.top_tc    = 1'b0;
      model_reset();

      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0, 1'b0);
      hold(100, 0, 0, 0);

      // Bouncing start button must never register.
      for (int i = 0; i < 5; i++) begin
         hold(2, 1, 0, 0);
         hold(2, 0, 0, 0);
      end
      hold(20, 0, 0, 0);

      // Clean start, ticks, pause and resume.
      hold(10, 1, 0, 0);  hold(30, 0, 0, 0);
      hold(10, 1, 0, 0);  hold(10, 0, 0, 0);
      hold(10, 1, 0, 0);  hold(20, 0, 0, 0);

      // Clear ignored in RUN; pause; simultaneous start+clear clears.
      hold(10, 0, 1, 0);  hold(20, 0, 0, 0);
      hold(10, 1, 0, 0);  hold(10, 0, 0, 0);
      hold(10, 1, 1, 0);  hold(10, 0, 0, 0);

      // Rollover into OVF, start ignored there, clear leaves it.
      hold(10, 1, 0, 0);  hold(20, 0, 0, 100);
      hold(10, 1, 0, 0);  hold(10, 0, 0, 0);
      hold(10, 0, 1, 0);  hold(10, 0, 0, 0);

      // Reset asserted while running.
      hold(10, 1, 0, 0);  hold(7, 0, 0, 0);
      cycle(1'b0, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b0);
      hold(10, 0, 0, 0);

      // Randomised button levels, occasional rollover and reset.
      for (int k = 0; k < 600; k++) begin
         len = $urandom_range(1, DC + 8);
         s   = ($urandom_range(0, 2) == 0);
         c   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) cycle(1'b0, 1'b0, 0, 1'b0);
         hold(len, s, c, 10);
      end

      hold(3, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
